// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul_ctrl
// Purpose  : Unsigned shift-and-add multiplier sequencer driving one shared
//            external WIDTH-bit adder; produces a 2*WIDTH-bit product.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_co
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_add  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_p;

  logic                 w_in_add;
  logic [2*WIDTH-1:0]   w_next;

  assign w_in_add = (r_state == c_add);
  // Carry enters the MSB while the consumed multiplier bit falls off the LSB.
  assign w_next   = {add_co, add_sum, r_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_m     <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= c_add;
          end
        end
        c_add: begin
          {r_acc, r_q} <= w_next;
          r_cnt        <= r_cnt + CNT_W'(1);
          // Product is registered on the final step so P is valid with done.
          if (r_cnt == c_last_cnt) begin
            r_p     <= w_next;
            r_state <= c_done;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign busy    = (r_state != c_idle);
  assign done    = (r_state == c_done);
  assign P       = r_p;
  assign add_a   = w_in_add ? r_acc : '0;
  assign add_b   = (w_in_add && r_q[0]) ? r_m : '0;
  assign add_cin = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mul_ctrl
// Purpose  : Scoreboard bench for shift_add_mul_ctrl with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   A = '0;
  logic [WIDTH-1:0]   B = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  shift_add_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .P       (P),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_co  (add_co)
  );

  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done and guards pulse width / P stability.
  logic [2*WIDTH-1:0] last_p    = '0;
  logic               skip      = 1'b1;
  logic               prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("busy_after_done", 64'(busy), 64'd0);
    if (done) begin
      check("done_width", 64'(prev_done), 64'd0);
      check("adder_idle_in_done", 64'({add_a, add_b, add_cin}), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("product", 64'(P), 64'(e.p));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
      last_p = P;
    end else if (skip) begin
      last_p = P;
    end else if (P !== last_p) begin
      check("p_stable", 64'(P), 64'(last_p));
      last_p = P;
    end
    skip      = rst;
    prev_done = done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    check("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Drives a one-cycle start; accepted on the next edge, done 16 edges later.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    wait_idle();
    A = a; B = b; start = 1'b1;
    e.p   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    e.cyc = cyc + WIDTH + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_p", 64'(P), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    @(posedge clk); #1;

    issue(16'd3, 16'd5);
    wait_drain();
    issue(16'hFFFF, 16'hFFFF);
    wait_drain();

    issue(16'h1234, 16'h0000);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (busy && !done) check("addb_zero_mult", 64'(add_b), 64'd0);
    end
    wait_drain();

    // start held through busy: only the op after DONE->IDLE may be accepted.
    wait_idle();
    A = 16'd7; B = 16'd9; start = 1'b1;
    e.p = 32'd63; e.cyc = cyc + WIDTH + 1; sb.push_back(e);
    e.p = 32'd4;  e.cyc = cyc + WIDTH + 1 + WIDTH + 2; sb.push_back(e);
    @(posedge clk); #1;
    A = 16'd2; B = 16'd2;
    repeat (WIDTH + 2) @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // Reset during the eighth ADD cycle aborts the operation.
    issue(16'hABCD, 16'h00EF);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_p", 64'(P), 64'd0);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    issue(16'h00FF, 16'h0101);
    wait_drain();

    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '0;
        2: rb = '1;
        default: ;
      endcase
      issue(ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1 start = 1'b0;
      end
      wait_drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
Sequential unsigned multiplier controller that time-shares one external WIDTH-bit ripple-carry adder to form a 2*WIDTH-bit product by shift-and-add.
- Owns the operand, accumulator and counter registers plus the FSM.
- Drives the adder's A/B/Cin inputs and consumes its SUM/Co outputs.
- Sits between a requesting unit (start/done handshake) and the adder instance in the top level.

Parameters:
- WIDTH, 16, operand width; also the width of the shared adder.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- A  input  WIDTH  multiplicand; captured on accepted start.
- B  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse when P is valid.
- P  output  2*WIDTH  product register; holds the last result.
- add_a  output  WIDTH  to adder A: accumulator high half.
- add_b  output  WIDTH  to adder B: multiplicand if the current multiplier LSB is 1, else 0.
- add_cin  output  1  to adder Cin: constant 0.
- add_sum  input  WIDTH  from adder SUM.
- add_co  input  1  from adder carry-out.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: state=IDLE, busy=0, done=0, P=0, internal M/ACC/Q/cnt=0.
- Reset mid-operation: aborts the operation, returns to IDLE and clears P. No done is generated.

FSM states: IDLE, ADD, DONE.
- IDLE, start=1: latch M<=A, Q<=B, ACC<=0, cnt<=0; go to ADD.
- IDLE, start=0: stay in IDLE.
- ADD, each cycle: the adder is purely combinational, so the result is used in the same cycle.
  - {ACC,Q} <= {add_co, add_sum, Q[WIDTH-1:1]}, i.e. a right shift with the carry entering the MSB.
  - cnt <= cnt+1.
  - After the cycle where cnt==WIDTH-1, go to DONE.
- DONE: P <= {ACC,Q}, done=1 for exactly this cycle, then go to IDLE.
  - Equivalent option: register P at the transition and pulse done in DONE. In either case P is valid whenever done=1 and stays stable until the next DONE.
- Latency: start accepted at edge N; WIDTH ADD cycles; done high in cycle N+WIDTH+1 (cycle 17 for WIDTH=16). The next start is accepted in the IDLE cycle after DONE, giving a WIDTH+2 cycle throughput.
- start while busy=1 (ADD or DONE) is ignored. It is not queued, and A/B changes during busy have no effect.
- add_a/add_b/add_cin are driven combinationally from registers. In IDLE/DONE they are 0 (adder output unused).
- Arithmetic: unsigned only. ACC plus carry never overflows 2*WIDTH bits; the max product (2^WIDTH-1)^2 fits exactly.
- No X propagation: all outputs defined from reset onward.

Test Plan:
- rst=1 for 2 cycles, then release -> busy=0, done=0, P=0, add_a=add_b=0, add_cin=0.
- A=3, B=5, start 1 cycle -> busy for 17 cycles; done pulses one cycle at start+17; P=0x0000000F; busy=0 the next cycle.
- A=0xFFFF, B=0xFFFF -> P=0xFFFE0001, exercising add_co=1 in the carry path. A=0x1234, B=0 -> P=0; add_b=0 every ADD cycle.
- A=7, B=9 accepted, then start held high with A=2, B=2 through busy -> exactly one done, P=0x3F. A second op starts on the first IDLE cycle after done, giving P=4 exactly WIDTH+2 cycles after the first done.
- Start an op, assert rst for 1 cycle in ADD cycle 8 -> next cycle state IDLE, busy=0, P=0, no done pulse. A new start then completes correctly (A=0x00FF, B=0x0101 -> P=0x0000FFFF).
- Random bench, 1000 unsigned pairs -> P matches A*B in every case; done is exactly 1 cycle wide; P stable between dones.
